instr_fetch_unit: RTL and testbench

// - Fetch stage directly upstream of the opcode decoder. Holds the PC and issues in-order requests to instruction memory.
// - Buffers returned words with their PC and presents {instr, op, pc, pc+4} to decode over a valid/ready handshake.
// - On a redirect from the branch/jump logic, flushes all wrong-path state and restarts fetching at the target.

---
 rtl/rv_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_unit_if.sv | 41 ++++
 rtl/fetch_buffer.sv | 76 +++++++
 rtl/instr_fetch_unit.sv | 89 ++++++++
 tb/tb_instr_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_fetch_pkg.sv
// Package for the instruction fetch stage.
// Holds the shared widths, the default reset PC, the buffer entry type and
// a small PC alignment helper. It is imported by the fetch interface, the
// fetch buffer and the fetch unit top.
package rv_fetch_pkg;

  localparam int XLEN     = 32;
  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 7;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic               filled;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Interface bundling the fetch unit's handshake and data signals.
//   imem request : imem_req_valid/ready, imem_req_addr
//   imem response: imem_rsp_valid, imem_rsp_data
//   redirect     : redirect, redirect_target
//   decode side  : instr_valid/ready, instr, op, instr_pc, instr_pc_plus4
//   status       : misaligned
// The master modport is the fetch unit; the slave modport is its environment
// (instruction memory, branch logic and decoder).
interface instr_fetch_unit_if;
  import rv_fetch_pkg::*;

  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [XLEN-1:0]      imem_req_addr;
  logic                 imem_rsp_valid;
  logic [INSTR_W-1:0]   imem_rsp_data;
  logic                 redirect;
  logic [XLEN-1:0]      redirect_target;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [INSTR_W-1:0]   instr;
  logic [OPCODE_W-1:0]  op;
  logic [XLEN-1:0]      instr_pc;
  logic [XLEN-1:0]      instr_pc_plus4;
  logic                 misaligned;

  modport master (
    output imem_req_valid, imem_req_addr,
    output instr_valid, instr, op, instr_pc, instr_pc_plus4, misaligned,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect, redirect_target, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  instr_valid, instr, op, instr_pc, instr_pc_plus4, misaligned,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect, redirect_target, instr_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Circular fetch buffer with three pointers.
//   alloc pointer: next free slot, written with {pc, filled=0} on i_alloc
//   fill pointer : oldest allocated-but-unfilled slot, written on i_fill
//   head pointer : oldest slot, presented on o_head and freed on i_pop
// i_flush drops every entry and rewinds all pointers.
// Ports: clk, rst_n, i_flush, i_alloc, i_alloc_pc, i_fill, i_fill_data,
//        i_pop, o_head, o_alloc_cnt (allocated entries), o_filled_cnt
//        (filled entries not yet popped).
module fetch_buffer
  import rv_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = PW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_alloc,
  input  logic [XLEN-1:0]    i_alloc_pc,
  input  logic               i_fill,
  input  logic [INSTR_W-1:0] i_fill_data,
  input  logic               i_pop,
  output fetch_entry_t       o_head,
  output logic [CW-1:0]      o_alloc_cnt,
  output logic [CW-1:0]      o_filled_cnt
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_alloc_ptr;
  logic [PW-1:0] r_fill_ptr;
  logic [PW-1:0] r_head_ptr;
  logic [CW-1:0] r_alloc_cnt;
  logic [CW-1:0] r_filled_cnt;

  // The alloc, fill and pop targets are always distinct slots: alloc goes to
  // a free slot, fill to an allocated unfilled slot, pop to the filled head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_alloc_ptr  <= '0;
      r_fill_ptr   <= '0;
      r_head_ptr   <= '0;
      r_alloc_cnt  <= '0;
      r_filled_cnt <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i].filled <= 1'b0;
      r_alloc_ptr  <= '0;
      r_fill_ptr   <= '0;
      r_head_ptr   <= '0;
      r_alloc_cnt  <= '0;
      r_filled_cnt <= '0;
    end else begin
      if (i_alloc) begin
        r_mem[r_alloc_ptr] <= '{instr: '0, pc: i_alloc_pc, filled: 1'b0};
        r_alloc_ptr        <= r_alloc_ptr + PW'(1);
      end
      if (i_fill) begin
        r_mem[r_fill_ptr].instr  <= i_fill_data;
        r_mem[r_fill_ptr].filled <= 1'b1;
        r_fill_ptr               <= r_fill_ptr + PW'(1);
      end
      if (i_pop) begin
        r_mem[r_head_ptr].filled <= 1'b0;
        r_head_ptr               <= r_head_ptr + PW'(1);
      end
      r_alloc_cnt  <= r_alloc_cnt + CW'(i_alloc) - CW'(i_pop);
      r_filled_cnt <= r_filled_cnt + CW'(i_fill) - CW'(i_pop);
    end
  end

  assign o_head       = r_mem[r_head_ptr];
  assign o_alloc_cnt  = r_alloc_cnt;
  assign o_filled_cnt = r_filled_cnt;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order imem requests, buffers
// returned words with their PC and presents {instr, op, pc, pc+4} to decode.
// A redirect flushes all wrong-path state; responses to requests that were
// already in flight are counted in r_drop_cnt and discarded on arrival.
// Ports: clk, rst_n (async, active low), bus (instr_fetch_unit_if.master).
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int CW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;
  // Headroom above DEPTH so a burst of back-to-back redirects cannot wrap.
  localparam int DW = CW + 1;

  logic [XLEN-1:0]    r_pc;
  logic [DW-1:0]      r_drop_cnt;
  logic               r_misaligned;

  fetch_entry_t       w_head;
  logic [CW-1:0]      w_alloc_cnt;
  logic [CW-1:0]      w_filled_cnt;
  logic [DW-1:0]      w_unfilled;
  logic               w_req_valid;
  logic               w_req_fire;
  logic               w_rsp_drop;
  logic               w_fill;
  logic               w_instr_valid;
  logic               w_pop;
  logic [INSTR_W-1:0] w_instr;

  // rst_n gates the request so nothing is offered while held in reset.
  assign w_req_valid   = rst_n && !bus.redirect && (w_alloc_cnt < CW'(DEPTH));
  assign w_req_fire    = w_req_valid && bus.imem_req_ready;
  assign w_rsp_drop    = bus.imem_rsp_valid && (r_drop_cnt != '0);
  assign w_fill        = bus.imem_rsp_valid && !bus.redirect && (r_drop_cnt == '0);
  assign w_instr_valid = w_head.filled && !bus.redirect;
  assign w_pop         = w_instr_valid && bus.instr_ready;
  assign w_unfilled    = DW'(w_alloc_cnt) - DW'(w_filled_cnt);

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (bus.redirect),
    .i_alloc      (w_req_fire),
    .i_alloc_pc   (r_pc),
    .i_fill       (w_fill),
    .i_fill_data  (bus.imem_rsp_data),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_alloc_cnt  (w_alloc_cnt),
    .o_filled_cnt (w_filled_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_drop_cnt   <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= bus.redirect && (bus.redirect_target[1:0] != 2'b00);
      if (bus.redirect) begin
        r_pc <= pc_align(bus.redirect_target);
        // Everything still owed by imem becomes wrong-path; a response landing
        // this cycle settles one of those debts, whichever request it was for.
        r_drop_cnt <= r_drop_cnt + w_unfilled - DW'(bus.imem_rsp_valid);
      end else begin
        if (w_req_fire) r_pc <= r_pc + XLEN'(4);
        if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - DW'(1);
      end
    end
  end

  assign w_instr            = w_instr_valid ? w_head.instr : '0;
  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.instr_valid    = w_instr_valid;
  assign bus.instr          = w_instr;
  assign bus.op             = w_instr[OPCODE_W-1:0];
  assign bus.instr_pc       = w_instr_valid ? w_head.pc : '0;
  assign bus.instr_pc_plus4 = w_instr_valid ? (w_head.pc + XLEN'(4)) : '0;
  assign bus.misaligned     = r_misaligned;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: table-driven start-up/backpressure vectors,
// hand-written redirect/misalign/reset sequences, a randomized phase against
// an in-order fetch-stream reference model, and a wrap-around instance.
module tb_instr_fetch_unit;
  import rv_fetch_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();
  instr_fetch_unit_if bus_w ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the fetch stream is a sequence of consecutive word
  // addresses restarting at each aligned redirect target. Decode must see
  // exactly that sequence with mem_word() contents; imem requests must walk it
  // too, and at most DEPTH fetched-but-unconsumed words may exist at once.
  logic [31:0] q_addr[$];
  int          q_cyc[$];
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] exp_pc, exp_req;
  int          occ;
  logic        exp_mis;
  int          delivered = 0;

  logic        s_rv, s_iv, s_mis;
  logic [31:0] s_ra, s_ipc;

  task automatic model_reset(input logic [31:0] rpc);
    exp_pc  = rpc;
    exp_req = rpc;
    occ     = 0;
    exp_mis = 1'b0;
    q_addr.delete();
    q_cyc.delete();
  endtask

  task automatic step();
    logic        fire_req, fire_instr, red;
    logic [31:0] tgt;
    if (q_addr.size() > 0 && (cyc - q_cyc[0]) >= lat) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(q_addr[0]);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    @(negedge clk);
    assert (!(bus.imem_rsp_valid && q_addr.size() == 0));
    red   = bus.redirect;
    tgt   = bus.redirect_target;
    s_rv  = bus.imem_req_valid;
    s_ra  = bus.imem_req_addr;
    s_iv  = bus.instr_valid;
    s_ipc = bus.instr_pc;
    s_mis = bus.misaligned;
    chk("misaligned", 32'(bus.misaligned), 32'(exp_mis));
    chk("req_valid", 32'(bus.imem_req_valid), 32'(!red && occ < DEPTH));
    if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_req);
    if (red) chk("instr_valid_in_redirect", 32'(bus.instr_valid), 0);
    if (bus.instr_valid) begin
      chk("instr_pc", bus.instr_pc, exp_pc);
      chk("instr", bus.instr, mem_word(exp_pc));
      chk("op", 32'(bus.op), 32'(mem_word(exp_pc) & 32'h7F));
      chk("pc_plus4", bus.instr_pc_plus4, exp_pc + 32'd4);
    end else begin
      chk("idle_instr", bus.instr, 0);
      chk("idle_pc", bus.instr_pc | bus.instr_pc_plus4 | 32'(bus.op), 0);
    end
    fire_req   = bus.imem_req_valid && bus.imem_req_ready;
    fire_instr = bus.instr_valid && bus.instr_ready;
    @(posedge clk);
    if (bus.imem_rsp_valid) begin
      void'(q_addr.pop_front());
      void'(q_cyc.pop_front());
    end
    if (fire_req) begin
      q_addr.push_back(bus.imem_req_addr);
      q_cyc.push_back(cyc);
    end
    if (red) begin
      exp_pc  = {tgt[31:2], 2'b00};
      exp_req = {tgt[31:2], 2'b00};
      occ     = 0;
    end else begin
      if (fire_req) begin exp_req += 32'd4; occ++; end
      if (fire_instr) begin exp_pc += 32'd4; occ--; delivered++; end
    end
    exp_mis = red && (tgt[1:0] != 2'b00);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = '0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;
    bus.instr_ready     = 1'b0;
    bus.imem_req_ready  = 1'b0;
    lat = 1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset(32'h0);
  endtask

  // Wrap-around instance: always-ready 1-cycle memory and always-ready decode.
  initial begin
    bus_w.imem_req_ready  = 1'b1;
    bus_w.instr_ready     = 1'b1;
    bus_w.redirect        = 1'b0;
    bus_w.redirect_target = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_w.imem_rsp_valid <= 1'b0;
      bus_w.imem_rsp_data  <= '0;
    end else begin
      bus_w.imem_rsp_valid <= bus_w.imem_req_valid && bus_w.imem_req_ready;
      bus_w.imem_rsp_data  <= mem_word(bus_w.imem_req_addr);
    end
  end

  logic [31:0] w_req_log[$], w_pc_log[$], w_p4_log[$], w_ins_log[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_w.imem_req_valid && bus_w.imem_req_ready && w_req_log.size() < 8)
        w_req_log.push_back(bus_w.imem_req_addr);
      if (bus_w.instr_valid && w_pc_log.size() < 8) begin
        w_pc_log.push_back(bus_w.instr_pc);
        w_p4_log.push_back(bus_w.instr_pc_plus4);
        w_ins_log.push_back(bus_w.instr);
      end
    end
  end

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] ra;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;

  vec_t tbl_start[7];
  vec_t tbl_bp[8];

  initial begin
    logic found;
    int   d0;

    // start-up, always-ready decode, 1-cycle imem
    tbl_start[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl_start[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl_start[2] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0};
    tbl_start[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
    tbl_start[4] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h0};
    tbl_start[5] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h8};
    tbl_start[6] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
    // decode stalled for 5 cycles, then released
    tbl_bp[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl_bp[1] = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl_bp[2] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
    tbl_bp[3] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
    tbl_bp[4] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
    tbl_bp[5] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0};
    tbl_bp[6] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
    tbl_bp[7] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h0};

    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = '0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;
    bus.instr_ready     = 1'b0;
    bus.imem_req_ready  = 1'b0;
    #3;
    chk("reset_req_valid", 32'(bus.imem_req_valid), 0);
    chk("reset_instr_valid", 32'(bus.instr_valid), 0);
    chk("reset_misaligned", 32'(bus.misaligned), 0);
    chk("reset_data", bus.instr | bus.instr_pc, 0);

    do_reset();
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.instr_ready = tbl_start[i].rdy;
      step();
      chk("tbl_start_rv", 32'(s_rv), 32'(tbl_start[i].rv));
      if (tbl_start[i].rv) chk("tbl_start_addr", s_ra, tbl_start[i].ra);
      chk("tbl_start_iv", 32'(s_iv), 32'(tbl_start[i].iv));
      if (tbl_start[i].iv) chk("tbl_start_pc", s_ipc, tbl_start[i].ipc);
    end

    do_reset();
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.instr_ready = tbl_bp[i].rdy;
      step();
      chk("tbl_bp_rv", 32'(s_rv), 32'(tbl_bp[i].rv));
      if (tbl_bp[i].rv) chk("tbl_bp_addr", s_ra, tbl_bp[i].ra);
      chk("tbl_bp_iv", 32'(s_iv), 32'(tbl_bp[i].iv));
      if (tbl_bp[i].iv) chk("tbl_bp_pc", s_ipc, tbl_bp[i].ipc);
    end

    // redirect with two requests outstanding and nothing filled
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    lat = 4;
    repeat (3) step();
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h100;
    step();
    chk("redir_cycle_iv", 32'(s_iv), 0);
    bus.redirect = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (s_iv) begin
        found = 1'b1;
        chk("redir_first_pc", s_ipc, 32'h100);
      end
    end
    chk("redir_delivered", 32'(found), 1);
    lat = 1;
    repeat (4) step();

    // misaligned redirect
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h102;
    step();
    bus.redirect = 1'b0;
    step();
    chk("mis_pulse", 32'(s_mis), 1);
    chk("mis_resume_rv", 32'(s_rv), 1);
    chk("mis_resume_addr", s_ra, 32'h100);
    step();
    chk("mis_pulse_end", 32'(s_mis), 0);
    repeat (4) step();

    // randomized traffic
    d0 = delivered;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0 && q_addr.size() == 0) lat = $urandom_range(1, 3);
      bus.instr_ready     = ($urandom_range(0, 9) < 7);
      bus.imem_req_ready  = ($urandom_range(0, 9) < 7);
      bus.redirect        = ($urandom_range(0, 19) == 0);
      bus.redirect_target = $urandom & 32'h0000_0FFF;
      step();
    end
    bus.redirect = 1'b0;
    chk("random_progress", 32'(delivered - d0 > 100), 1);

    // async reset with two entries filled
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b0;
    repeat (4) step();
    chk("pre_reset_iv", 32'(bus.instr_valid), 1);
    #2;
    rst_n = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    #1;
    chk("async_rst_iv", 32'(bus.instr_valid), 0);
    chk("async_rst_rv", 32'(bus.imem_req_valid), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset(32'h0);
    bus.instr_ready = 1'b1;
    step();
    chk("post_rst_addr", s_ra, 32'h0);
    chk("post_rst_iv", 32'(s_iv), 0);
    repeat (6) step();

    // wrap-around instance
    chk("wrap_logs", 32'(w_req_log.size() >= 2 && w_pc_log.size() >= 2), 1);
    if (w_req_log.size() >= 2 && w_pc_log.size() >= 2) begin
      chk("wrap_req0", w_req_log[0], 32'hFFFF_FFFC);
      chk("wrap_req1", w_req_log[1], 32'h0);
      chk("wrap_pc0", w_pc_log[0], 32'hFFFF_FFFC);
      chk("wrap_p4_0", w_p4_log[0], 32'h0);
      chk("wrap_ins0", w_ins_log[0], mem_word(32'hFFFF_FFFC));
      chk("wrap_pc1", w_pc_log[1], 32'h0);
      chk("wrap_p4_1", w_p4_log[1], 32'h4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
